pdm_capture_ctrl: RTL and testbench
===================================

// Module: pdm_capture_ctrl
// PURPOSE
//  Sequencer for the PDM Deserializer. Gates its enable and discards its first
//  warm-up samples while the decimation filter settles. Writes each later 16-bit
//  sample into a sample RAM at an incrementing address.
//  Sits between the user control logic (record button/FSM) and the Deserializer + sample BRAM.
// PARAMETERS
//  ADDR_W          14     sample RAM address width
//  DEPTH           16384  samples per record; 1 <= DEPTH <= 2**ADDR_W
//  WARMUP_SAMPLES  4      des_done_i pulses discarded after each start; 0 = none
// PORTS
//  clock_i        in   1           system clock, all logic on rising edge
//  reset_i        in   1           synchronous, active-high reset
//  start_i        in   1           1-cycle pulse: begin a record
//  stop_i         in   1           1-cycle pulse: end record early
//  loop_i         in   1           sampled at start: 1 = circular capture until stop_i
//  des_enable_o   out  1           to Deserializer enable_i
//  des_done_i     in   1           from Deserializer done_o; 1-cycle sample-valid pulse
//  des_data_i     in   16          from Deserializer data_o; valid when des_done_i=1
//  mem_we_o       out  1           sample RAM write enable
//  mem_addr_o     out  ADDR_W      sample RAM write address
//  mem_data_o     out  16          sample RAM write data
//  busy_o         out  1           1 in WARMUP or CAPTURE
//  done_o         out  1           1-cycle pulse when a record completes
//  count_o        out  ADDR_W+1    samples written in current/last record, saturates at DEPTH
//  wrapped_o      out  1           sticky: loop mode wrapped past DEPTH-1; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal warm-up counter and loop latch 0.
//   Applies on any cycle, including mid-record. No pending write survives reset.
//  States: IDLE, WARMUP, CAPTURE, DONE. All outputs are registered.
//  IDLE:
//   - start_i=1: latch loop_i, clear count_o/wrapped_o, set address to 0.
//   - Go to WARMUP, or to CAPTURE if WARMUP_SAMPLES=0.
//   - stop_i is ignored.
//  WARMUP:
//   - Each des_done_i increments the warm-up counter; data is dropped, no write.
//   - On the WARMUP_SAMPLES-th pulse, go to CAPTURE.
//   - stop_i: go to DONE.
//  CAPTURE:
//   - des_done_i at cycle t: at t+1, mem_we_o=1 for exactly 1 cycle, with
//     mem_data_o = des_data_i(t) and mem_addr_o = current address.
//   - The address then increments.
//   - count_o increments, saturating at DEPTH.
//  Record end (non-loop): the DEPTH-th write goes to DONE in the same cycle it
//   is issued.
//  Loop mode: after the write at address DEPTH-1, the address wraps to 0 and
//   wrapped_o is set. Capture continues until stop_i.
//  stop_i in CAPTURE: go to DONE.
//   - If des_done_i arrives in the same cycle, that sample is still written at t+1.
//  DONE: done_o=1 for 1 cycle, des_enable_o=0, then IDLE.
//   - count_o and wrapped_o hold until the next start.
//  des_enable_o: 1 in WARMUP/CAPTURE, 0 otherwise. It rises the cycle after start is accepted.
//  busy_o equals des_enable_o.
//  start_i while busy or in DONE is ignored.
//  Simultaneous start_i and stop_i in IDLE: start wins.
//  mem_addr_o/mem_data_o hold their last value when mem_we_o=0.
//  des_done_i in IDLE/DONE is ignored.
// TESTING
//  Bench params: DEPTH=8, WARMUP_SAMPLES=2, ADDR_W=3. Drive des_done_i every 20 cycles with data 0x1000+n.
//  1 Reset held 5 cycles mid-CAPTURE -> next cycle all outputs 0, state IDLE,
//    no mem_we_o.
//  2 start_i, loop_i=0:
//    - Pulses n=0,1 dropped.
//    - n=2..9 written to addr 0..7 with data 0x1002..0x1009, each 1 cycle after its pulse.
//    - done_o pulse, count_o=8, des_enable_o falls with done.
//  3 start_i, loop_i=1, 12 captured pulses, then stop_i:
//    - Addr sequence 0..7,0..3; wrapped_o=1; count_o=8; done_o once.
//  4 stop_i during WARMUP (after 1 pulse) -> no writes, done_o pulse, count_o=0.
//  5 stop_i coincident with des_done_i in CAPTURE -> that sample written next cycle, then done_o.
//    start_i pulsed while busy -> ignored; address sequence unaffected.
//  6 WARMUP_SAMPLES=0 build: first des_done_i after start -> written to addr 0.

Source files
------------

// File: rtl/pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdm_capture_ctrl
// Description : Sequencer for the PDM deserializer. Discards warm-up samples,
//               then writes captured samples to sample RAM at rising addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_capture_ctrl #(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int WARMUP_SAMPLES = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    output logic              des_enable_o,
    input  logic              des_done_i,
    input  logic [15:0]       des_data_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic              wrapped_o
);

    localparam int WU_W        = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;
    localparam int WARM_LAST_I = (WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0;

    localparam logic [WU_W-1:0]   WARM_LAST  = WU_W'(WARM_LAST_I);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   FINAL_CNT  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept_start;
    logic              capture_wr;
    logic              loop_mode;
    logic [WU_W-1:0]   warm_cnt;
    logic [ADDR_W-1:0] addr;
    logic              enable;

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        capture_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    state_nxt    = (WARMUP_SAMPLES == 0) ? CAPTURE : WARMUP;
                end
            end
            WARMUP: begin
                if (stop_i)
                    state_nxt = DONE;
                else if (des_done_i && warm_cnt == WARM_LAST)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                capture_wr = des_done_i;
                // The final non-loop write and the DONE state appear together
                if (stop_i)
                    state_nxt = DONE;
                else if (des_done_i && !loop_mode && count_o == FINAL_CNT)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= IDLE;
            enable     <= 1'b0;
            done_o     <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            count_o    <= '0;
            wrapped_o  <= 1'b0;
            loop_mode  <= 1'b0;
            warm_cnt   <= '0;
            addr       <= '0;
        end else begin
            state    <= state_nxt;
            enable   <= (state_nxt == WARMUP) || (state_nxt == CAPTURE);
            done_o   <= (state_nxt == DONE);
            mem_we_o <= capture_wr;

            if (accept_start) begin
                loop_mode <= loop_i;
                count_o   <= '0;
                wrapped_o <= 1'b0;
                addr      <= '0;
                warm_cnt  <= '0;
            end

            if (state == WARMUP && des_done_i)
                warm_cnt <= warm_cnt + WU_W'(1);

            if (capture_wr) begin
                mem_addr_o <= addr;
                mem_data_o <= des_data_i;
                if (addr == LAST_ADDR) begin
                    addr <= '0;
                    if (loop_mode)
                        wrapped_o <= 1'b1;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
                if (count_o != DEPTH_CNT)
                    count_o <= count_o + (ADDR_W + 1)'(1);
            end
        end
    end

    assign des_enable_o = enable;
    assign busy_o       = enable;

endmodule
`default_nettype wire

// File: tb/tb_pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_capture_ctrl
// Description : Scoreboard bench for pdm_capture_ctrl (DEPTH=8, 2 warm-up
//               samples) plus a zero-warm-up instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        start_b = 1'b0;
    logic        stop_i = 1'b0;
    logic        loop_i = 1'b0;
    logic        des_done_i = 1'b0;
    logic        des_done_b = 1'b0;
    logic [15:0] des_data_i = '0;

    logic        des_enable_o, mem_we_o, busy_o, done_o, wrapped_o;
    logic [2:0]  mem_addr_o;
    logic [15:0] mem_data_o;
    logic [3:0]  count_o;

    logic        en_b, we_b, busy_b, done_b, wrapped_b;
    logic [2:0]  addr_b;
    logic [15:0] data_b;
    logic [3:0]  count_b;

    pdm_capture_ctrl #(.ADDR_W(3), .DEPTH(8), .WARMUP_SAMPLES(2)) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
        .loop_i(loop_i), .des_enable_o(des_enable_o), .des_done_i(des_done_i),
        .des_data_i(des_data_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .busy_o(busy_o), .done_o(done_o),
        .count_o(count_o), .wrapped_o(wrapped_o)
    );

    pdm_capture_ctrl #(.ADDR_W(3), .DEPTH(8), .WARMUP_SAMPLES(0)) dut_b (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_b), .stop_i(stop_i),
        .loop_i(loop_i), .des_enable_o(en_b), .des_done_i(des_done_b),
        .des_data_i(des_data_i), .mem_we_o(we_b), .mem_addr_o(addr_b),
        .mem_data_o(data_b), .busy_o(busy_b), .done_o(done_b),
        .count_o(count_b), .wrapped_o(wrapped_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        int          stamp;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every RAM write must match the head of the expected queue
    always @(negedge clk) begin
        if (done_o === 1'b1) done_seen++;
        if (mem_we_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: addr=%0d data=0x%0h with nothing expected (cycle %0d)",
                         mem_addr_o, mem_data_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mem_addr_o === e.a && mem_data_o === e.d && cyc == e.stamp)
                    n_pass++;
                else
                    $display("FAIL write: got addr=%0d data=0x%0h cycle=%0d, expected addr=%0d data=0x%0h cycle=%0d",
                             mem_addr_o, mem_data_o, cyc, e.a, e.d, e.stamp);
            end
        end
    end

    // Deserializer pulse 20 cycles apart; optionally expect a write one cycle later
    task automatic pulse(input logic [15:0] data, input bit expect_wr, input logic [2:0] a,
                         input bit with_stop);
        exp_t e;
        repeat (19) @(negedge clk);
        des_done_i = 1'b1;
        des_data_i = data;
        stop_i     = with_stop;
        if (expect_wr) begin
            e.a = a; e.d = data; e.stamp = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        des_done_i = 1'b0;
        stop_i     = 1'b0;
    endtask

    task automatic start_rec(input bit lp);
        @(negedge clk);
        start_i = 1'b1;
        loop_i  = lp;
        @(negedge clk);
        start_i = 1'b0;
        loop_i  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(mem_we_o), 0);
        check({tag, "_addr"}, 32'(mem_addr_o), 0);
        check({tag, "_data"}, 32'(mem_data_o), 0);
        check({tag, "_count"}, 32'(count_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_enable"}, 32'(des_enable_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_wrapped"}, 32'(wrapped_o), 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        check_all_zero("reset");

        // Plain record: 2 dropped, 8 written, done with the last write
        d0 = done_seen;
        start_rec(1'b0);
        check("enable_after_start", 32'(des_enable_o), 1);
        for (int n = 0; n < 10; n++)
            pulse(16'h1000 + 16'(n), n >= 2, 3'(n - 2), 1'b0);
        check("rec_done_pulse", 32'(done_o), 1);
        check("rec_enable_falls", 32'(des_enable_o), 0);
        check("rec_count", 32'(count_o), 8);
        repeat (2) @(negedge clk);
        check("rec_done_once", 32'(done_seen - d0), 1);
        check("rec_idle", 32'(busy_o), 0);

        // Loop record: 12 writes wrap the address, stop ends it
        d0 = done_seen;
        start_rec(1'b1);
        for (int n = 0; n < 14; n++)
            pulse(16'h1000 + 16'(n), n >= 2, 3'((n - 2) % 8), 1'b0);
        check("loop_busy", 32'(busy_o), 1);
        repeat (3) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("loop_done_pulse", 32'(done_o), 1);
        check("loop_wrapped", 32'(wrapped_o), 1);
        check("loop_count", 32'(count_o), 8);
        repeat (2) @(negedge clk);
        check("loop_done_once", 32'(done_seen - d0), 1);

        // Stop during warm-up: no writes, wrapped cleared by start
        start_rec(1'b0);
        check("warm_wrapped_cleared", 32'(wrapped_o), 0);
        check("warm_count_cleared", 32'(count_o), 0);
        pulse(16'h1000, 1'b0, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("warm_stop_done", 32'(done_o), 1);
        check("warm_stop_count", 32'(count_o), 0);

        // Stop coincident with a sample, plus an ignored start while busy
        start_rec(1'b0);
        for (int n = 0; n < 5; n++) begin
            pulse(16'h1000 + 16'(n), n >= 2, 3'(n - 2), 1'b0);
            if (n == 3) begin
                repeat (5) @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        end
        pulse(16'h1005, 1'b1, 3'd3, 1'b1);
        check("coinc_done", 32'(done_o), 1);
        check("coinc_count", 32'(count_o), 4);
        check("coinc_enable", 32'(des_enable_o), 0);

        // Reset in the middle of a capture, with a sample in flight
        start_rec(1'b0);
        for (int n = 0; n < 3; n++)
            pulse(16'h1000 + 16'(n), n >= 2, 3'd0, 1'b0);
        repeat (19) @(negedge clk);
        des_done_i = 1'b1;
        des_data_i = 16'h1003;
        reset_i    = 1'b1;
        @(negedge clk);
        des_done_i = 1'b0;
        repeat (4) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        pulse(16'h1007, 1'b0, 3'd0, 1'b0);
        check("idle_pulse_ignored", 32'(busy_o), 0);

        // Zero warm-up build: first sample lands at address 0
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("nw_enable", 32'(en_b), 1);
        repeat (5) @(negedge clk);
        des_done_b = 1'b1;
        des_data_i = 16'h2000;
        @(negedge clk);
        des_done_b = 1'b0;
        check("nw_we", 32'(we_b), 1);
        check("nw_addr", 32'(addr_b), 0);
        check("nw_data", 32'(data_b), 32'h2000);
        check("nw_count", 32'(count_b), 1);

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
